// File: rtl/step_pkg.sv
// Shared types and constants for the stepper pulse generator and its timer.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } state_t;

    localparam int WIDTH_WORK_DEFAULT = 16;

    typedef logic [WIDTH_WORK_DEFAULT:0] period_t;

    // Shortest legal step period: the pulse plus an equally long low time.
    function automatic int min_period(input int pulse_width);
        return 2 * pulse_width;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter: a load of N makes done rise on the N-th cycle after the load edge.
module step_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value - WIDTH'(1);
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper driver pulse generator: turns period/direction/enable requests into
// step pulses with fixed width, direction setup time and a signed position count.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int WIDTH_WORK  = 16,
    parameter int PULSE_WIDTH = 50,
    parameter int DIR_SETUP   = 25,
    parameter int POS_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_WORK:0]   period_in,
    input  logic                  period_valid,
    input  logic                  enable_in,
    input  logic                  dir_in,
    output logic                  drv_step,
    output logic                  drv_dir,
    output logic                  drv_enable,
    output logic                  busy,
    output logic [POS_WIDTH-1:0]  position
);

    localparam int PERIOD_W = WIDTH_WORK + 1;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(min_period(PULSE_WIDTH));
    localparam logic [PERIOD_W-1:0] PULSE_LEN  = PERIOD_W'(PULSE_WIDTH);
    localparam logic [PERIOD_W-1:0] SETUP_LEN  = PERIOD_W'(DIR_SETUP);

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   period_pend_q, period_pend_d;
    logic [PERIOD_W-1:0]   period_act_q, period_act_d;
    logic                  drv_step_q, drv_step_d;
    logic                  drv_dir_q, drv_dir_d;
    logic                  drv_enable_q, drv_enable_d;
    logic                  busy_q, busy_d;
    logic [POS_WIDTH-1:0]  position_q, position_d;

    logic                  tmr_load;
    logic [PERIOD_W-1:0]   tmr_value;
    logic                  tmr_done;
    logic [PERIOD_W-1:0]   period_raw;
    logic [PERIOD_W-1:0]   period_eff;
    logic [POS_WIDTH-1:0]  pos_delta;

    step_timer #(
        .WIDTH(PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    // A strobe arriving on the decision cycle itself is used straight away.
    assign period_raw = period_valid ? period_in : period_pend_q;
    assign period_eff = (period_raw != '0 && period_raw < MIN_PERIOD) ? MIN_PERIOD : period_raw;
    assign pos_delta  = drv_dir_q ? POS_WIDTH'(1) : '1;

    always_comb begin
        state_d       = state_q;
        period_pend_d = period_valid ? period_in : period_pend_q;
        period_act_d  = period_act_q;
        drv_step_d    = drv_step_q;
        drv_dir_d     = drv_dir_q;
        drv_enable_d  = drv_enable_q;
        position_d    = position_q;
        tmr_load      = 1'b0;
        tmr_value     = '0;

        unique case (state_q)
            IDLE: begin
                drv_step_d   = 1'b0;
                drv_enable_d = 1'b0;
                if (enable_in && period_eff != '0) begin
                    state_d      = SETUP;
                    drv_enable_d = 1'b1;
                    drv_dir_d    = dir_in;
                    period_act_d = period_eff;
                    tmr_load     = 1'b1;
                    tmr_value    = SETUP_LEN;
                end
            end
            SETUP: begin
                if (!enable_in) begin
                    state_d      = IDLE;
                    drv_enable_d = 1'b0;
                end else if (tmr_done) begin
                    state_d    = HIGH;
                    drv_step_d = 1'b1;
                    position_d = position_q + pos_delta;
                    tmr_load   = 1'b1;
                    tmr_value  = PULSE_LEN;
                end
            end
            HIGH: begin
                // The pulse always runs its full width; enable is only looked at afterwards.
                if (tmr_done) begin
                    drv_step_d = 1'b0;
                    if (!enable_in) begin
                        state_d      = IDLE;
                        drv_enable_d = 1'b0;
                    end else begin
                        state_d   = LOW;
                        tmr_load  = 1'b1;
                        tmr_value = period_act_q - PULSE_LEN;
                    end
                end
            end
            LOW: begin
                if (!enable_in || (tmr_done && period_eff == '0)) begin
                    state_d      = IDLE;
                    drv_enable_d = 1'b0;
                end else if (tmr_done) begin
                    period_act_d = period_eff;
                    if (dir_in != drv_dir_q) begin
                        state_d   = SETUP;
                        drv_dir_d = dir_in;
                        tmr_load  = 1'b1;
                        tmr_value = SETUP_LEN;
                    end else begin
                        state_d    = HIGH;
                        drv_step_d = 1'b1;
                        position_d = position_q + pos_delta;
                        tmr_load   = 1'b1;
                        tmr_value  = PULSE_LEN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            period_pend_q <= '0;
            period_act_q  <= '0;
            drv_step_q    <= 1'b0;
            drv_dir_q     <= 1'b0;
            drv_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            position_q    <= '0;
        end else begin
            state_q       <= state_d;
            period_pend_q <= period_pend_d;
            period_act_q  <= period_act_d;
            drv_step_q    <= drv_step_d;
            drv_dir_q     <= drv_dir_d;
            drv_enable_q  <= drv_enable_d;
            busy_q        <= busy_d;
            position_q    <= position_d;
        end
    end

    assign drv_step   = drv_step_q;
    assign drv_dir    = drv_dir_q;
    assign drv_enable = drv_enable_q;
    assign busy       = busy_q;
    assign position   = position_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus randomized period/direction
// changes, checked against step timing computed from rise-to-rise arithmetic.
module tb_step_pulse_gen;
    import step_pkg::*;

    localparam int PULSE_WIDTH = 50;
    localparam int DIR_SETUP   = 25;
    localparam int POS_WIDTH   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    period_t              period_in;
    logic                 period_valid;
    logic                 enable_in;
    logic                 dir_in;
    logic                 drv_step;
    logic                 drv_dir;
    logic                 drv_enable;
    logic                 busy;
    logic [POS_WIDTH-1:0] position;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_rise   = 0;
    logic prev_step   = 1'b0;
    int   model_pos   = 0;
    int   cur_period  = 0;
    logic cur_dir     = 1'b0;

    int                   rise_cyc_q[$];
    logic [POS_WIDTH-1:0] rise_pos_q[$];
    int                   width_q[$];

    step_pulse_gen #(
        .WIDTH_WORK  (WIDTH_WORK_DEFAULT),
        .PULSE_WIDTH (PULSE_WIDTH),
        .DIR_SETUP   (DIR_SETUP),
        .POS_WIDTH   (POS_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .period_in    (period_in),
        .period_valid (period_valid),
        .enable_in    (enable_in),
        .dir_in       (dir_in),
        .drv_step     (drv_step),
        .drv_dir      (drv_dir),
        .drv_enable   (drv_enable),
        .busy         (busy),
        .position     (position)
    );

    always #5 clk = ~clk;

    function automatic int clamp_period(input int p);
        if (p != 0 && p < 2 * PULSE_WIDTH) return 2 * PULSE_WIDTH;
        return p;
    endfunction

    // One clock; logs step rises (cycle, position) and completed pulse widths.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (drv_step === 1'b1 && prev_step === 1'b0) begin
            rise_cyc_q.push_back(cyc);
            rise_pos_q.push_back(position);
            last_rise = cyc;
        end
        if (drv_step === 1'b0 && prev_step === 1'b1) begin
            width_q.push_back(cyc - last_rise);
        end
        prev_step = drv_step;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_log();
        rise_cyc_q.delete();
        rise_pos_q.delete();
        width_q.delete();
    endtask

    task automatic wait_rise(input int budget, output bit got);
        int n0;
        n0  = rise_cyc_q.size();
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_cyc_q.size() > n0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic strobe_period(input int p);
        period_in    = period_t'(p);
        period_valid = 1'b1;
        tick();
        period_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_in = 1'b0; dir_in = 1'b0; period_valid = 1'b0; period_in = '0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (drv_step !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drv_step: got %b expected 0", drv_step); end
        vectors++;
        if (drv_dir !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drv_dir: got %b expected 0", drv_dir); end
        vectors++;
        if (drv_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drv_enable: got %b expected 0", drv_enable); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (position !== '0) begin miscompares++; $display("[TB] FAIL reset_position: got %0d expected 0", $signed(position)); end
        // A zero period means stop, so enable alone must not start motion.
        enable_in = 1'b1;
        tick();
        tick();
        vectors++;
        if (drv_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_period_start: drv_enable got %b expected 0", drv_enable); end
        enable_in = 1'b0;
        tick();
    endtask

    task automatic test_start();
        int t0;
        strobe_period(800);
        clear_log();
        model_pos = 0;
        t0 = cyc;
        dir_in = 1'b1;
        enable_in = 1'b1;
        tick();
        vectors++;
        if (drv_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL start_enable: got %b expected 1", drv_enable); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL start_busy: got %b expected 1", busy); end
        run_to(t0 + 1 + DIR_SETUP + 1600 + 60);
        vectors++;
        if (rise_cyc_q.size() != 3) begin miscompares++; $display("[TB] FAIL start_rise_count: got %0d expected 3", rise_cyc_q.size()); end
        for (int i = 0; i < rise_cyc_q.size() && i < 3; i++) begin
            vectors++;
            if (rise_cyc_q[i] != t0 + 1 + DIR_SETUP + 800 * i) begin
                miscompares++; $display("[TB] FAIL start_rise%0d: got cycle %0d expected %0d", i, rise_cyc_q[i] - t0, 1 + DIR_SETUP + 800 * i);
            end
            vectors++;
            if (rise_pos_q[i] !== POS_WIDTH'(i + 1)) begin
                miscompares++; $display("[TB] FAIL start_pos%0d: got %0d expected %0d", i, $signed(rise_pos_q[i]), i + 1);
            end
        end
        for (int i = 0; i < width_q.size(); i++) begin
            vectors++;
            if (width_q[i] != PULSE_WIDTH) begin miscompares++; $display("[TB] FAIL start_width%0d: got %0d expected %0d", i, width_q[i], PULSE_WIDTH); end
        end
        model_pos = 3;
    endtask

    task automatic test_period_update();
        bit got;
        int r;
        int exp_rise[4];
        clear_log();
        wait_rise(900, got);
        vectors++;
        if (!got) begin miscompares++; $display("[TB] FAIL upd_first_rise: got none expected a rise within 900 cycles"); end
        r = got ? last_rise : cyc;
        run_to(r + 70);
        strobe_period(39600);
        run_to(r + 860);
        strobe_period(800);
        run_to(r + 41260);
        exp_rise = '{r, r + 800, r + 40400, r + 41200};
        vectors++;
        if (rise_cyc_q.size() != 4) begin miscompares++; $display("[TB] FAIL upd_rise_count: got %0d expected 4", rise_cyc_q.size()); end
        for (int i = 0; i < rise_cyc_q.size() && i < 4; i++) begin
            vectors++;
            if (rise_cyc_q[i] != exp_rise[i]) begin
                miscompares++; $display("[TB] FAIL upd_rise%0d: got offset %0d expected %0d", i, rise_cyc_q[i] - r, exp_rise[i] - r);
            end
            vectors++;
            if (rise_pos_q[i] !== POS_WIDTH'(model_pos + 1 + i)) begin
                miscompares++; $display("[TB] FAIL upd_pos%0d: got %0d expected %0d", i, $signed(rise_pos_q[i]), model_pos + 1 + i);
            end
        end
        for (int i = 0; i < width_q.size(); i++) begin
            vectors++;
            if (width_q[i] != PULSE_WIDTH) begin miscompares++; $display("[TB] FAIL upd_width%0d: got %0d expected %0d", i, width_q[i], PULSE_WIDTH); end
        end
        model_pos = model_pos + 4;
    endtask

    task automatic test_dir_flip();
        bit got;
        int r;
        int exp_rise[3];
        clear_log();
        wait_rise(900, got);
        vectors++;
        if (!got) begin miscompares++; $display("[TB] FAIL flip_first_rise: got none expected a rise within 900 cycles"); end
        r = got ? last_rise : cyc;
        run_to(r + 10);
        dir_in = 1'b0;
        run_to(r + 799);
        vectors++;
        if (drv_dir !== 1'b1) begin miscompares++; $display("[TB] FAIL flip_dir_held: got %b expected 1", drv_dir); end
        tick();
        vectors++;
        if (drv_dir !== 1'b0) begin miscompares++; $display("[TB] FAIL flip_dir_changed: got %b expected 0", drv_dir); end
        run_to(r + 1685);
        exp_rise = '{r, r + 800 + DIR_SETUP, r + 1600 + DIR_SETUP};
        vectors++;
        if (rise_cyc_q.size() != 3) begin miscompares++; $display("[TB] FAIL flip_rise_count: got %0d expected 3", rise_cyc_q.size()); end
        for (int i = 0; i < rise_cyc_q.size() && i < 3; i++) begin
            vectors++;
            if (rise_cyc_q[i] != exp_rise[i]) begin
                miscompares++; $display("[TB] FAIL flip_rise%0d: got offset %0d expected %0d", i, rise_cyc_q[i] - r, exp_rise[i] - r);
            end
            vectors++;
            if (rise_pos_q[i] !== POS_WIDTH'(model_pos + 1 - i)) begin
                miscompares++; $display("[TB] FAIL flip_pos%0d: got %0d expected %0d", i, $signed(rise_pos_q[i]), model_pos + 1 - i);
            end
        end
        for (int i = 0; i < width_q.size(); i++) begin
            vectors++;
            if (width_q[i] != PULSE_WIDTH) begin miscompares++; $display("[TB] FAIL flip_width%0d: got %0d expected %0d", i, width_q[i], PULSE_WIDTH); end
        end
        model_pos = model_pos - 1;
    endtask

    task automatic test_clamp_stop();
        bit got;
        int r;
        int exp_rise[4];
        clear_log();
        wait_rise(900, got);
        vectors++;
        if (!got) begin miscompares++; $display("[TB] FAIL clamp_first_rise: got none expected a rise within 900 cycles"); end
        r = got ? last_rise : cyc;
        run_to(r + 60);
        strobe_period(30);
        run_to(r + 1010);
        strobe_period(0);
        run_to(r + 1099);
        vectors++;
        if (drv_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_enable_before: got %b expected 1", drv_enable); end
        tick();
        vectors++;
        if (drv_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_enable_after: got %b expected 0", drv_enable); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_busy: got %b expected 0", busy); end
        run_to(r + 1300);
        exp_rise = '{r, r + 800, r + 900, r + 1000};
        vectors++;
        if (rise_cyc_q.size() != 4) begin miscompares++; $display("[TB] FAIL clamp_rise_count: got %0d expected 4", rise_cyc_q.size()); end
        for (int i = 0; i < rise_cyc_q.size() && i < 4; i++) begin
            vectors++;
            if (rise_cyc_q[i] != exp_rise[i]) begin
                miscompares++; $display("[TB] FAIL clamp_rise%0d: got offset %0d expected %0d", i, rise_cyc_q[i] - r, exp_rise[i] - r);
            end
            vectors++;
            if (rise_pos_q[i] !== POS_WIDTH'(model_pos - 1 - i)) begin
                miscompares++; $display("[TB] FAIL clamp_pos%0d: got %0d expected %0d", i, $signed(rise_pos_q[i]), model_pos - 1 - i);
            end
        end
        model_pos = model_pos - 4;
    endtask

    task automatic test_disable_mid_pulse();
        bit got;
        int r;
        int c0;
        clear_log();
        c0 = cyc;
        dir_in = 1'b0;
        period_in = period_t'(800);
        period_valid = 1'b1;
        enable_in = 1'b1;
        tick();
        period_valid = 1'b0;
        vectors++;
        if (drv_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL bypass_enable: got %b expected 1", drv_enable); end
        wait_rise(100, got);
        r = got ? last_rise : cyc;
        vectors++;
        if (r != c0 + 1 + DIR_SETUP) begin miscompares++; $display("[TB] FAIL dis_first_rise: got offset %0d expected %0d", r - c0, 1 + DIR_SETUP); end
        model_pos = model_pos - 1;
        run_to(r + 10);
        enable_in = 1'b0;
        run_to(r + PULSE_WIDTH - 1);
        vectors++;
        if (drv_step !== 1'b1 || drv_enable !== 1'b1) begin
            miscompares++; $display("[TB] FAIL dis_pulse_kept: got step=%b enable=%b expected 1/1", drv_step, drv_enable);
        end
        tick();
        vectors++;
        if (drv_step !== 1'b0 || drv_enable !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL dis_stop: got step=%b enable=%b busy=%b expected 0/0/0", drv_step, drv_enable, busy);
        end
        run_to(r + 1000);
        vectors++;
        if (rise_cyc_q.size() != 1) begin miscompares++; $display("[TB] FAIL dis_rise_count: got %0d expected 1", rise_cyc_q.size()); end
        vectors++;
        if (position !== POS_WIDTH'(model_pos)) begin miscompares++; $display("[TB] FAIL dis_position: got %0d expected %0d", $signed(position), model_pos); end
        vectors++;
        if (width_q.size() != 1 || width_q[0] != PULSE_WIDTH) begin
            miscompares++; $display("[TB] FAIL dis_width: got %0d pulses first %0d expected 1 pulse of %0d", width_q.size(), (width_q.size() > 0) ? width_q[0] : -1, PULSE_WIDTH);
        end
    endtask

    task automatic test_reset_mid_high();
        bit got;
        int r;
        int c0;
        clear_log();
        dir_in = 1'b1;
        enable_in = 1'b1;
        wait_rise(100, got);
        r = got ? last_rise : cyc;
        run_to(r + 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (drv_step !== 1'b0 || drv_enable !== 1'b0 || busy !== 1'b0 || drv_dir !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rst_high_outputs: got step=%b enable=%b busy=%b dir=%b expected all 0", drv_step, drv_enable, busy, drv_dir);
        end
        vectors++;
        if (position !== '0) begin miscompares++; $display("[TB] FAIL rst_high_position: got %0d expected 0", $signed(position)); end
        model_pos = 0;
        tick();
        tick();
        vectors++;
        if (drv_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pend_cleared: drv_enable got %b expected 0", drv_enable); end
        enable_in = 1'b0;
        tick();
        strobe_period(800);
        clear_log();
        c0 = cyc;
        enable_in = 1'b1;
        tick();
        vectors++;
        if (drv_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_enable: got %b expected 1", drv_enable); end
        wait_rise(100, got);
        r = got ? last_rise : cyc;
        vectors++;
        if (r != c0 + 1 + DIR_SETUP) begin miscompares++; $display("[TB] FAIL restart_rise: got offset %0d expected %0d", r - c0, 1 + DIR_SETUP); end
        model_pos = 1;
        vectors++;
        if (position !== POS_WIDTH'(model_pos)) begin miscompares++; $display("[TB] FAIL restart_position: got %0d expected 1", $signed(position)); end
        cur_period = 800;
        cur_dir = 1'b1;
    endtask

    task automatic test_random();
        bit got;
        int r;
        int off;
        int p;
        int nd;
        int exp_rise;
        for (int iter = 0; iter < 8; iter++) begin
            r   = last_rise;
            off = $urandom_range(cur_period - 2, 1);
            p   = $urandom_range(1000, 1);
            nd  = $urandom_range(1, 0);
            run_to(r + off);
            period_in = period_t'(p);
            period_valid = 1'b1;
            dir_in = (nd != 0);
            tick();
            period_valid = 1'b0;
            exp_rise = r + cur_period + (((nd != 0) != cur_dir) ? DIR_SETUP : 0);
            wait_rise(cur_period + 200, got);
            vectors++;
            if (!got || last_rise != exp_rise) begin
                miscompares++; $display("[TB] FAIL rand%0d_rise: got offset %0d expected %0d", iter, got ? last_rise - r : -1, exp_rise - r);
            end
            model_pos = model_pos + ((nd != 0) ? 1 : -1);
            vectors++;
            if (position !== POS_WIDTH'(model_pos)) begin
                miscompares++; $display("[TB] FAIL rand%0d_position: got %0d expected %0d", iter, $signed(position), model_pos);
            end
            vectors++;
            if (width_q.size() == 0 || width_q[$] != PULSE_WIDTH) begin
                miscompares++; $display("[TB] FAIL rand%0d_width: got %0d expected %0d", iter, (width_q.size() > 0) ? width_q[$] : -1, PULSE_WIDTH);
            end
            cur_period = clamp_period(p);
            cur_dir = (nd != 0);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_period_update();
        test_dir_flip();
        test_clamp_stop();
        test_disable_mid_pulse();
        test_reset_mid_high();
        test_random();
        enable_in = 1'b0;
        repeat (60) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
